intp_mu_nco: RTL
================

Name: intp_mu_nco

Overview:
- Timing/phase controller that drives the fp19 Farrow interpolator: it supplies the sample-load strobe and the per-output fractional delay mu.
- A fixed-point phase accumulator with programmable step sets the resampling ratio. Each accumulator wrap pulls one input sample through a valid/ready handshake and forwards it to the interpolator.
- The accumulator fraction is converted to fp19 (1 sign, 8 exp, bias 127, 10 mantissa) and presented as mu, one output per cycle.

Parameters:
- PHASE_W, 16, accumulator width; mu = acc / 2^PHASE_W, range [0,1)
- FP_W, 19, float word width
- EXP_W, 8, exponent width
- MAN_W, 10, mantissa width
- PRIME_N, 4, samples loaded before the first mu is issued (Farrow tap count)

Ports:
- clk  in  1  clock; all flops posedge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; 0 forces IDLE
- step  in  PHASE_W  phase increment per output; sampled on the IDLE->PRIME transition only
- in_valid  in  1  upstream sample valid
- in_data  in  FP_W  upstream fp19 sample
- in_ready  out  1  combinational; a sample is accepted when in_valid & in_ready
- x_load  out  1  registered; 1-cycle strobe, shift x_data into the interpolator delay line
- x_data  out  FP_W  registered; sample accompanying x_load
- mu_valid  out  1  registered; mu_out is valid
- mu_out  out  FP_W  registered; fp19 mu
- underrun  out  1  registered; sticky, set on STALL entry

Behaviour:
- Reset: state IDLE; acc, step_r, x_load, x_data, mu_valid, mu_out, underrun, prime_cnt all 0.
- IDLE:
  - in_ready=0, outputs 0.
  - en=1 -> PRIME: step_r<=step, acc<=0, prime_cnt<=0, underrun<=0.
- PRIME:
  - in_ready=1.
  - Each accepted sample: x_load<=1, x_data<=in_data, prime_cnt++.
  - On the PRIME_N-th accept, also emit mu_valid<=1, mu_out<=0 -> RUN.
  - mu_valid=0 on all other PRIME cycles.
- RUN, with {c,sum} = acc + step_r (PHASE_W+1 bits):
  - c=0: in_ready=0, acc<=sum, mu_valid<=1, mu_out<=fp19(sum), x_load<=0.
  - c=1 and in_valid: in_ready=1, accept; acc<=sum (wrapped); x_load<=1, x_data<=in_data, mu_valid<=1, mu_out<=fp19(sum). x_load and mu for the new base sample occur in the same cycle.
  - c=1 and !in_valid: -> STALL; acc held, mu_valid<=0, x_load<=0, underrun<=1.
- STALL:
  - in_ready=1; acc held; mu_valid=0.
  - On accept, perform the c=1 RUN update from the held acc, then -> RUN.
- Latency: one cycle from the accept (or add) to registered outputs.
- en=0 in any state -> IDLE next cycle, all outputs cleared. The sticky underrun is held until the next IDLE->PRIME.
- step_r=0: mu_out=0 every cycle, no loads; legal.
- step_r change while running: ignored until the next IDLE pass.
- fp19(a):
  - a=0 -> all zeros.
  - Otherwise p = index of the leading one (PHASE_W-1..0).
  - Exponent = 127 + p - PHASE_W.
  - Mantissa = the MAN_W bits below the leading one, zero-padded on the LSB side, truncated (no rounding).
  - Sign = 0.
- Output is never denormal: minimum exponent for PHASE_W=16 is 111.

Decomposition:
- Package intp_pkg holds:
  - FP_W, EXP_W, MAN_W, FP_BIAS=127
  - state encoding (IDLE, PRIME, RUN, STALL)
  - FP19_ZERO constant
- One sub-module: fix2fp19, a combinational unsigned fraction to fp19 converter (leading-one detect, shift, exponent calc), parameterized by PHASE_W. It is reused later by the decimator path.

Test Plan:
- Prime: step=0x1C72, en=1, in_valid=1 with data A,B,C,D -> x_load on 4 consecutive cycles carrying A..D. mu_valid only on the D cycle with mu_out=0x00000.
- 9x ratio: continue after prime.
  - First RUN output is mu_out=0x1EF1C (acc=7282).
  - 8 outputs pass with no load (acc up to 58256).
  - The 9th cycle accepts sample E: x_load=1, acc=2, mu_out=0x1C000.
- Converter points via acc: 0x8000 -> 0x1F800; 0x4000 -> 0x1F400; 0xC000 -> 0x1FA00; 0x0001 -> {0,111,0} = 0x1BC00.
- Underrun: in_valid=0 when a carry is due -> STALL, mu_valid=0, underrun=1, acc held. Raise in_valid 3 cycles later -> accept, x_load=1, mu resumes with fp19(held acc + step mod 2^16). underrun stays 1.
- Mid-run disable: en=0 during RUN -> next cycle state IDLE, mu_valid=x_load=in_ready=0, mu_out=0. Re-enable with step=0x8000 -> re-prime 4 samples; underrun cleared; outputs alternate 0x1F800 / 0 (with load).
- Async reset: assert rst_n=0 mid-STALL off-edge -> all outputs 0 immediately. After release, no activity until en.

Source files
------------

// File: rtl/intp_mu_nco_pkg.sv
// Shared fp19 format constants and controller state encoding for the
// interpolator timing path.
package intp_pkg;

    localparam int unsigned FP_W    = 19;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 10;
    localparam int unsigned FP_BIAS = 127;

    localparam logic [FP_W-1:0] FP19_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        STALL
    } state_e;

endpackage

// File: rtl/intp_mu_nco_if.sv
// Sample handshake and interpolator-side bus of the mu NCO.
//   in_valid/in_data/in_ready : upstream fp19 samples (valid/ready)
//   x_load/x_data             : delay-line shift strobe and sample
//   mu_valid/mu_out           : fractional delay for the Farrow stage
interface intp_mu_nco_if;
    import intp_pkg::*;

    logic            in_valid;
    logic [FP_W-1:0] in_data;
    logic            in_ready;
    logic            x_load;
    logic [FP_W-1:0] x_data;
    logic            mu_valid;
    logic [FP_W-1:0] mu_out;

    modport master (
        output in_valid, in_data,
        input  in_ready, x_load, x_data, mu_valid, mu_out
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, x_load, x_data, mu_valid, mu_out
    );

endinterface

// File: rtl/intp_mu_nco_fix2fp19.sv
// Combinational unsigned fraction (a / 2^PHASE_W) to fp19 converter.
//   a  : unsigned fraction
//   fp : fp19 {sign=0, exp, mantissa}, truncated; all zeros for a == 0
module fix2fp19
    import intp_pkg::*;
#(
    parameter int unsigned PHASE_W = 16
) (
    input  logic [PHASE_W-1:0] a,
    output logic [FP_W-1:0]    fp
);

    int               lead_c;
    int               exp_c;
    logic [MAN_W-1:0] man_c;

    // Leading-one detect, normalise, then drop the hidden one via the cast.
    always_comb begin
        lead_c = 0;
        for (int i = 0; i < int'(PHASE_W); i++) begin
            if (a[i]) begin
                lead_c = i;
            end
        end
        exp_c = int'(FP_BIAS) + lead_c - int'(PHASE_W);
        man_c = MAN_W'(({a, MAN_W'(0)} << (int'(PHASE_W) - 1 - lead_c)) >> (PHASE_W - 1));
        fp    = (a == '0) ? FP19_ZERO : {1'b0, EXP_W'(exp_c), man_c};
    end

endmodule

// File: rtl/intp_mu_nco.sv
// Phase accumulator NCO driving the fp19 Farrow interpolator: each wrap pulls
// one input sample, every cycle in RUN issues a mu = acc / 2^PHASE_W.
//   clk, rst_n : clock, async active-low reset
//   en         : run enable (0 returns to IDLE)
//   step       : phase increment, captured on IDLE->PRIME
//   bus        : sample handshake in, x_load/x_data and mu out
//   underrun   : sticky, set when a sample was due but not available
module intp_mu_nco
    import intp_pkg::*;
#(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned PRIME_N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] step,
    intp_mu_nco_if.slave       bus,
    output logic               underrun
);

    localparam int unsigned CNT_W = $clog2(PRIME_N + 1);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               x_load_q, x_load_d;
    logic [FP_W-1:0]    x_data_q, x_data_d;
    logic               mu_valid_q, mu_valid_d;
    logic [FP_W-1:0]    mu_out_q, mu_out_d;
    logic               underrun_q, underrun_d;
    logic               in_ready_c;
    logic [PHASE_W-1:0] sum;
    logic               carry;
    logic [FP_W-1:0]    sum_fp;

    assign {carry, sum} = {1'b0, acc_q} + {1'b0, step_q};

    fix2fp19 #(.PHASE_W(PHASE_W)) u_fix2fp19 (
        .a  (sum),
        .fp (sum_fp)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            x_load_q   <= 1'b0;
            x_data_q   <= '0;
            mu_valid_q <= 1'b0;
            mu_out_q   <= FP19_ZERO;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            x_load_q   <= x_load_d;
            x_data_q   <= x_data_d;
            mu_valid_q <= mu_valid_d;
            mu_out_q   <= mu_out_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        x_load_d   = 1'b0;
        x_data_d   = x_data_q;
        mu_valid_d = 1'b0;
        mu_out_d   = mu_out_q;
        underrun_d = underrun_q;
        in_ready_c = 1'b0;

        if (!en) begin
            state_d  = IDLE;
            x_data_d = '0;
            mu_out_d = FP19_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = PRIME;
                    step_d     = step;
                    acc_d      = '0;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                    x_data_d   = '0;
                    mu_out_d   = FP19_ZERO;
                end
                PRIME: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        x_load_d = 1'b1;
                        x_data_d = bus.in_data;
                        cnt_d    = cnt_q + CNT_W'(1);
                        // Last tap filled: first mu sits on the newest sample.
                        if (cnt_q == CNT_W'(PRIME_N - 1)) begin
                            mu_valid_d = 1'b1;
                            mu_out_d   = FP19_ZERO;
                            state_d    = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!carry) begin
                        acc_d      = sum;
                        mu_valid_d = 1'b1;
                        mu_out_d   = sum_fp;
                    end else begin
                        in_ready_c = 1'b1;
                        if (bus.in_valid) begin
                            acc_d      = sum;
                            x_load_d   = 1'b1;
                            x_data_d   = bus.in_data;
                            mu_valid_d = 1'b1;
                            mu_out_d   = sum_fp;
                        end else begin
                            state_d    = STALL;
                            underrun_d = 1'b1;
                        end
                    end
                end
                STALL: begin
                    // acc is held, so sum still holds the pending wrap.
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        acc_d      = sum;
                        x_load_d   = 1'b1;
                        x_data_d   = bus.in_data;
                        mu_valid_d = 1'b1;
                        mu_out_d   = sum_fp;
                        state_d    = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.x_load   = x_load_q;
    assign bus.x_data   = x_data_q;
    assign bus.mu_valid = mu_valid_q;
    assign bus.mu_out   = mu_out_q;
    assign underrun     = underrun_q;

endmodule
